sram_frame_scheduler: RTL

Controller for the LED frame buffer built on the 1RW1R inferred SRAM. It owns both SRAM ports. Port 0 serves single-outstanding host read/write transactions. Port 1 runs a frame readout engine that streams `length` consecutive words from `base_addr` to the LED serializer over a valid/ready interface, using credit-limited prefetch to absorb the SRAM's 2-cycle read latency.

---
 rtl/sram_frame_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sram_frame_scheduler.sv
// rtl/sram_frame_scheduler.sv - LED frame buffer controller: host port on SRAM port 0, prefetching frame readout on port 1
module sram_frame_scheduler #(
    parameter int ASIZE      = 8,
    parameter int DSIZE      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [ASIZE-1:0] host_addr,
    input  logic [DSIZE-1:0] host_wdata,
    output logic             host_ack,
    output logic [DSIZE-1:0] host_rdata,
    input  logic             start,
    input  logic [ASIZE-1:0] base_addr,
    input  logic [ASIZE:0]   length,
    output logic             busy,
    output logic             done,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [DSIZE-1:0] pix_data,
    output logic             pix_last,
    output logic             sram_cs0_n,
    output logic             sram_we0_n,
    output logic [ASIZE-1:0] sram_addr0,
    output logic [DSIZE-1:0] sram_wdata0,
    input  logic [DSIZE-1:0] sram_rdata0,
    output logic             sram_cs1_n,
    output logic [ASIZE-1:0] sram_addr1,
    input  logic [DSIZE-1:0] sram_rdata1
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {H_IDLE, H_W1, H_W2} host_state_t;
    typedef enum logic [1:0] {F_IDLE, F_RUN, F_DRAIN} frame_state_t;

    host_state_t  host_q, host_d;
    frame_state_t frame_q, frame_d;

    logic [ASIZE-1:0] base_q;
    logic [ASIZE:0]   len_q;
    logic [ASIZE:0]   idx_q;
    logic             zero_done_q;
    logic [1:0]       infl_v_q;
    logic [1:0]       infl_last_q;
    logic [DSIZE-1:0] fifo_data [FIFO_DEPTH];
    logic             fifo_last [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;

    logic       start_ok, issue, issue_last, push, pop, drain_empty, credit_ok;
    logic [1:0] inflight_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) host_q <= H_IDLE;
        else     host_q <= host_d;
    end

    always_comb begin
        host_d      = host_q;
        sram_cs0_n  = 1'b1;
        sram_we0_n  = 1'b1;
        sram_addr0  = '0;
        sram_wdata0 = '0;
        host_ack    = 1'b0;
        host_rdata  = '0;
        case (host_q)
            H_IDLE: begin
                if (host_req) begin
                    sram_cs0_n  = 1'b0;
                    sram_we0_n  = ~host_we;
                    sram_addr0  = host_addr;
                    sram_wdata0 = host_wdata;
                    host_d      = H_W1;
                end
            end
            H_W1: host_d = H_W2;
            H_W2: begin
                host_ack   = 1'b1;
                host_rdata = sram_rdata0;
                host_d     = H_IDLE;
            end
            default: host_d = H_IDLE;
        endcase
    end

    // Credits count both FIFO entries and reads still in the SRAM pipeline.
    assign inflight_cnt = {1'b0, infl_v_q[0]} + {1'b0, infl_v_q[1]};
    assign credit_ok    = (count_q + {1'b0, inflight_cnt}) < (PW+1)'(FIFO_DEPTH);
    assign start_ok     = start && (frame_q == F_IDLE);
    assign issue        = (frame_q == F_RUN) && credit_ok;
    assign issue_last   = (idx_q == len_q - (ASIZE+1)'(1));
    assign push         = infl_v_q[1];
    assign pix_valid    = (count_q != '0);
    assign pop          = pix_valid && pix_ready;
    assign drain_empty  = (count_q == '0) && (infl_v_q == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_q <= F_IDLE;
        else     frame_q <= frame_d;
    end

    always_comb begin
        frame_d = frame_q;
        case (frame_q)
            F_IDLE:  if (start_ok && (length != '0)) frame_d = F_RUN;
            F_RUN:   if (issue && issue_last) frame_d = F_DRAIN;
            F_DRAIN: if (drain_empty) frame_d = F_IDLE;
            default: frame_d = F_IDLE;
        endcase
    end

    assign done       = zero_done_q || ((frame_q == F_DRAIN) && drain_empty);
    assign busy       = (frame_q == F_RUN) || ((frame_q == F_DRAIN) && !drain_empty);
    assign sram_cs1_n = ~issue;
    assign sram_addr1 = issue ? (base_q + idx_q[ASIZE-1:0]) : '0;
    assign pix_data   = pix_valid ? fifo_data[rd_ptr_q] : '0;
    assign pix_last   = pix_valid ? fifo_last[rd_ptr_q] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            zero_done_q <= 1'b0;
            infl_v_q    <= '0;
            infl_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            zero_done_q <= start_ok && (length == '0);
            if (start_ok) begin
                base_q <= base_addr;
                len_q  <= length;
                idx_q  <= '0;
            end else if (issue) begin
                idx_q <= idx_q + (ASIZE+1)'(1);
            end
            infl_v_q    <= {infl_v_q[0], issue};
            infl_last_q <= {infl_last_q[0], issue && issue_last};
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: outputs are gated by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= sram_rdata1;
            fifo_last[wr_ptr_q] <= infl_last_q[1];
        end
    end
endmodule
